clink_frame_tx: RTL and testbench

- Camera Link base-configuration transmitter and camera emulator: drives the 4-lane X data and X clock that the image reader deserialises.
- Generates FVAL/LVAL/DVAL frame timing, pulls 24-bit pixels from a valid/ready stream and serialises 28-bit words 7:1 onto 4 lanes.
- Sits in bench and loopback builds; LVDS output buffers are external.

---
 rtl/clink_pkg.sv | 25 ++
 rtl/clink_serializer_7to1.sv | 65 ++++++
 rtl/clink_frame_tx.sv | 209 ++++++++++++++++++++
 tb/tb_clink_frame_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clink_pkg.sv
// Shared constants and types for the Camera Link base-configuration transmitter.
package clink_pkg;

  // Bit slots per serial word and the width of a slot counter.
  localparam int CLINK_SLOTS = 7;
  localparam int SLOT_W      = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CLINK_SLOTS - 1);

  // Serial clock level driven in each slot; bit s belongs to slot s.
  localparam logic [CLINK_SLOTS-1:0] CLK_PATTERN = 7'b1100011;

  // Control bit positions inside the 28-bit parallel word.
  localparam int PIX_W    = 24;
  localparam int LVAL_BIT = 24;
  localparam int FVAL_BIT = 25;
  localparam int DVAL_BIT = 26;

  // Timing generator state describing the next word to be serialised.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    VBLANK = 2'd2
  } state_e;

endpackage

// File: rtl/clink_serializer_7to1.sv
// 7:1 serialiser: free-running slot counter, parallel word load once per
// word, per-lane LSB-first shifting and the serial clock pattern.
module clink_serializer_7to1
  import clink_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CLINK_SLOTS*LINES-1:0] word_i,
  output logic                         load_strobe_o,
  output logic                         last_slot_o,
  output logic                         x_clk_o,
  output logic [LINES-1:0]             x_data_o
);

  localparam int WORD_W = CLINK_SLOTS * LINES;

  // slot_q is the slot the next clock edge puts on the pins, so the first
  // edge after reset presents slot 0 and loads a fresh word.
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              x_clk_q, x_clk_d;
  logic [LINES-1:0]  x_data_q, x_data_d;
  logic [WORD_W-1:0] src;

  // The edge leaving slot 6 loads word_i; the cycle before it shows slot 6.
  assign load_strobe_o = (slot_q == '0);
  assign last_slot_o   = (slot_q == LAST_SLOT);

  // Next slot, clock level and lane bits, shifting each lane towards bit 0.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    slot_d   = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
    x_clk_d  = CLK_PATTERN[slot_q];
    src      = load_strobe_o ? word_i : shift_q;
    shift_d  = '0;
    x_data_d = '0;
    for (int k = 0; k < LINES; k++) begin
      x_data_d[k]                      = src[CLINK_SLOTS*k];
      shift_d[CLINK_SLOTS*k +: CLINK_SLOTS] =
        {1'b0, src[CLINK_SLOTS*k+1 +: CLINK_SLOTS-1]};
    end
  end

  // Serialiser state and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      shift_q  <= '0;
      x_clk_q  <= 1'b0;
      x_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      slot_q   <= slot_d;
      shift_q  <= shift_d;
      x_clk_q  <= x_clk_d;
      x_data_q <= x_data_d;
    end
  end

  assign x_clk_o  = x_clk_q;
  assign x_data_o = x_data_q;

endmodule

// File: rtl/clink_frame_tx.sv
// Camera Link base-configuration transmitter / camera emulator: generates
// FVAL/LVAL/DVAL frame timing, pulls pixels from a valid/ready stream and
// hands 28-bit words to the 7:1 serialiser.
module clink_frame_tx
  import clink_pkg::*;
#(
  parameter int LINES   = 4,
  parameter int H_WIDTH = 12,
  parameter int V_WIDTH = 12
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic               enable,
  input  logic [H_WIDTH-1:0] h_active,
  input  logic [H_WIDTH-1:0] h_blank,
  input  logic [V_WIDTH-1:0] v_active,
  input  logic [V_WIDTH-1:0] v_blank,
  input  logic [PIX_W-1:0]   pixel_tdata,
  input  logic               pixel_tvalid,
  output logic               pixel_tready,
  output logic               clink_X_clk,
  output logic [LINES-1:0]   clink_X_data,
  output logic               busy,
  output logic [15:0]        frame_count,
  output logic               underrun,
  input  logic               underrun_clr
);

  localparam int WORD_W = CLINK_SLOTS * LINES;
  localparam int LINE_W = H_WIDTH + 1;

  // Timing state describes the word that the next load edge will serialise.
  state_e             state_q, state_d;
  logic [LINE_W-1:0]  x_q, x_d;
  logic [V_WIDTH-1:0] y_q, y_d;

  // Frame geometry captured at frame start.
  logic [H_WIDTH-1:0] h_act_q, h_act_d;
  logic [LINE_W-1:0]  line_len_q, line_len_d;
  logic [V_WIDTH-1:0] v_act_q, v_act_d;
  logic [V_WIDTH-1:0] v_blank_q, v_blank_d;

  logic [15:0]        frame_count_q, frame_count_d;
  logic               underrun_q, underrun_d;
  logic               tready_q, tready_d;
  logic               busy_q, busy_d;

  logic               load_strobe;
  logic               last_slot;
  logic               pend_fval;
  logic               pend_lval;
  logic               pix_accept;
  logic               x_wrap;
  logic               frame_end;
  logic               frame_start;
  logic [WORD_W-1:0]  word_next;

  assign pend_fval  = (state_q == ACTIVE);
  assign pend_lval  = pend_fval && (x_q < {1'b0, h_act_q});
  assign pix_accept = pend_lval && pixel_tvalid;
  assign x_wrap     = (x_q == line_len_q - LINE_W'(1));

  // Build the upcoming word; a missing pixel leaves data and DVAL at zero.
  always_comb begin
    word_next           = '0;
    word_next[FVAL_BIT] = pend_fval;
    word_next[LVAL_BIT] = pend_lval;
    word_next[DVAL_BIT] = pix_accept;
    if (pix_accept) begin
      word_next[PIX_W-1:0] = pixel_tdata;
    end
  end

  // Frame timing: advance x/y once per word, handle frame end and restart.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    h_act_d       = h_act_q;
    line_len_d    = line_len_q;
    v_act_d       = v_act_q;
    v_blank_d     = v_blank_q;
    frame_count_d = frame_count_q;
    frame_end     = 1'b0;
    frame_start   = 1'b0;

    if (load_strobe) begin
      unique case (state_q)
        IDLE: begin
          frame_start = enable;
        end
        ACTIVE: begin
          if (x_wrap) begin
            x_d = '0;
            if (y_q == v_act_q - V_WIDTH'(1)) begin
              y_d = '0;
              if (v_blank_q == '0) begin
                frame_end = 1'b1;
              end else begin
                state_d = VBLANK;
              end
            end else begin
              y_d = y_q + V_WIDTH'(1);
            end
          end else begin
            x_d = x_q + LINE_W'(1);
          end
        end
        VBLANK: begin
          if (x_wrap) begin
            x_d = '0;
            if (y_q == v_blank_q - V_WIDTH'(1)) begin
              y_d       = '0;
              frame_end = 1'b1;
            end else begin
              y_d = y_q + V_WIDTH'(1);
            end
          end else begin
            x_d = x_q + LINE_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // A finished frame counts even when enable has dropped meanwhile.
      if (frame_end) begin
        frame_count_d = frame_count_q + 16'd1;
        if (enable) begin
          frame_start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      // Geometry is sampled only here, so mid-frame edits wait for the next frame.
      if (frame_start) begin
        state_d    = ACTIVE;
        x_d        = '0;
        y_d        = '0;
        h_act_d    = h_active;
        line_len_d = {1'b0, h_active} + {1'b0, h_blank};
        v_act_d    = v_active;
        v_blank_d  = v_blank;
      end
    end
  end

  // Handshake window, sticky underrun (clear wins) and busy flag.
  always_comb begin
    tready_d   = last_slot && pend_lval;
    underrun_d = underrun_q;
    if (load_strobe && pend_lval && !pixel_tvalid) begin
      underrun_d = 1'b1;
    end
    if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // Timing and status registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      h_act_q       <= '0;
      line_len_q    <= '0;
      v_act_q       <= '0;
      v_blank_q     <= '0;
      frame_count_q <= '0;
      underrun_q    <= 1'b0;
      tready_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      h_act_q       <= h_act_d;
      line_len_q    <= line_len_d;
      v_act_q       <= v_act_d;
      v_blank_q     <= v_blank_d;
      frame_count_q <= frame_count_d;
      underrun_q    <= underrun_d;
      tready_q      <= tready_d;
      busy_q        <= busy_d;
    end
  end

  clink_serializer_7to1 #(
    .LINES (LINES)
  ) u_serializer (
    .clk           (s_axi_aclk),
    .rst_n         (s_axi_aresetn),
    .word_i        (word_next),
    .load_strobe_o (load_strobe),
    .last_slot_o   (last_slot),
    .x_clk_o       (clink_X_clk),
    .x_data_o      (clink_X_data)
  );

  assign pixel_tready = tready_q;
  assign busy         = busy_q;
  assign frame_count  = frame_count_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_clink_frame_tx.sv
// Self-checking bench for clink_frame_tx: a lane deserialiser rebuilds each
// 28-bit word and compares it against words queued by a frame model.
module tb_clink_frame_tx;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn;
  logic        enable;
  logic [11:0] h_active, h_blank, v_active, v_blank;
  logic [23:0] pixel_tdata;
  logic        pixel_tvalid;
  logic        pixel_tready;
  logic        clink_X_clk;
  logic [3:0]  clink_X_data;
  logic        busy;
  logic [15:0] frame_count;
  logic        underrun;
  logic        underrun_clr;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic        mon_en   = 1'b1;
  logic        in_frame = 1'b0;
  int          bslot    = 0;
  logic [31:0] cur      = '0;

  int drv_pix   = 0;
  int drv_data  = 1;
  int mdl_pix   = 0;
  int mdl_data  = 1;
  int drop_pix  = -1;

  logic [6:0] pat = 7'b1100011;

  clink_frame_tx #(
    .LINES   (4),
    .H_WIDTH (12),
    .V_WIDTH (12)
  ) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .enable        (enable),
    .h_active      (h_active),
    .h_blank       (h_blank),
    .v_active      (v_active),
    .v_blank       (v_blank),
    .pixel_tdata   (pixel_tdata),
    .pixel_tvalid  (pixel_tvalid),
    .pixel_tready  (pixel_tready),
    .clink_X_clk   (clink_X_clk),
    .clink_X_data  (clink_X_data),
    .busy          (busy),
    .frame_count   (frame_count),
    .underrun      (underrun),
    .underrun_clr  (underrun_clr)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Queue the words one frame should produce, in order.
  task automatic push_frame(input int ha, input int hb, input int va, input int vb);
    for (int y = 0; y < va; y++) begin
      for (int x = 0; x < ha + hb; x++) begin
        if (x < ha) begin
          if (mdl_pix == drop_pix) begin
            exp_q.push_back(32'h0300_0000);
          end else begin
            exp_q.push_back(32'h0700_0000 | 32'(mdl_data));
            mdl_data++;
          end
          mdl_pix++;
        end else begin
          exp_q.push_back(32'h0200_0000);
        end
      end
    end
    for (int i = 0; i < vb * (ha + hb); i++) exp_q.push_back(32'h0000_0000);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge s_axi_aclk);
      n++;
    end
    check(tag, {31'b0, busy}, {31'b0, lvl});
  endtask

  // Pixel source: offers the next value while tready is up, unless this
  // pixel slot is the one chosen to go missing.
  always @(negedge s_axi_aclk) begin
    if (s_axi_aresetn !== 1'b1) begin
      pixel_tvalid = 1'b0;
    end else if (pixel_tready) begin
      if (drv_pix == drop_pix) begin
        pixel_tvalid = 1'b0;
      end else begin
        pixel_tvalid = 1'b1;
        pixel_tdata  = 24'(drv_data);
        drv_data++;
      end
      drv_pix++;
    end else begin
      pixel_tvalid = 1'b0;
    end
  end

  // Lane deserialiser and scoreboard compare.
  always @(negedge s_axi_aclk) begin
    if (s_axi_aresetn !== 1'b1) begin
      bslot = 0;
      cur   = '0;
    end else begin
      for (int k = 0; k < 4; k++) cur[7*k + bslot] = clink_X_data[k];
      if (bslot == 6) begin
        if (mon_en) begin
          if (!in_frame && cur[25]) in_frame = 1'b1;
          if (in_frame) begin
            if (exp_q.size() == 0) begin
              check("sb_unexpected_word", cur, 32'h0);
              in_frame = 1'b0;
            end else begin
              check("sb_word", cur, exp_q.pop_front());
              if (exp_q.size() == 0) in_frame = 1'b0;
            end
          end
        end
        cur = '0;
      end
      bslot = (bslot == 6) ? 0 : bslot + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    s_axi_aresetn = 1'b0;
    enable        = 1'b0;
    h_active      = 12'd2;
    h_blank       = 12'd1;
    v_active      = 12'd2;
    v_blank       = 12'd1;
    pixel_tdata   = '0;
    pixel_tvalid  = 1'b0;
    underrun_clr  = 1'b0;

    // Reset state.
    repeat (3) @(negedge s_axi_aclk);
    check("reset_outputs", {8'b0, pixel_tready, clink_X_clk, clink_X_data, busy, underrun, frame_count},
          32'h0);
    @(negedge s_axi_aclk);
    #1 s_axi_aresetn = 1'b1;

    // Clock pattern with enable low: three full words of idle.
    for (int i = 0; i < 21; i++) begin
      @(negedge s_axi_aclk);
      check("idle_clk_pattern", {31'b0, clink_X_clk}, {31'b0, pat[i % 7]});
      check("idle_lanes_busy", {27'b0, clink_X_data, busy}, 32'h0);
    end

    // 2x2 frame, enable dropped during line 1.
    push_frame(2, 1, 2, 1);
    enable = 1'b1;
    wait_busy(1'b1, 20, "frame_a_start");
    repeat (28) @(negedge s_axi_aclk);
    enable = 1'b0;
    wait_busy(1'b0, 200, "frame_a_idle");
    repeat (14) @(negedge s_axi_aclk);
    check("frame_a_count", {16'b0, frame_count}, 32'd1);
    check("frame_a_underrun", {31'b0, underrun}, 32'd0);
    check("frame_a_sb_empty", exp_q.size(), 32'd0);

    // Same frame with the second pixel missing.
    drop_pix = mdl_pix + 1;
    push_frame(2, 1, 2, 1);
    enable = 1'b1;
    wait_busy(1'b1, 20, "frame_b_start");
    repeat (28) @(negedge s_axi_aclk);
    enable = 1'b0;
    wait_busy(1'b0, 200, "frame_b_idle");
    repeat (14) @(negedge s_axi_aclk);
    drop_pix = -1;
    check("frame_b_count", {16'b0, frame_count}, 32'd2);
    check("frame_b_sb_empty", exp_q.size(), 32'd0);
    check("underrun_set", {31'b0, underrun}, 32'd1);
    repeat (10) @(negedge s_axi_aclk);
    check("underrun_sticky", {31'b0, underrun}, 32'd1);
    underrun_clr = 1'b1;
    @(negedge s_axi_aclk);
    underrun_clr = 1'b0;
    check("underrun_cleared", {31'b0, underrun}, 32'd0);

    // h_active changed mid-frame: this frame keeps 3-word lines, next uses 6.
    push_frame(2, 1, 2, 1);
    push_frame(5, 1, 2, 1);
    enable = 1'b1;
    wait_busy(1'b1, 20, "frame_c_start");
    repeat (14) @(negedge s_axi_aclk);
    h_active = 12'd5;
    n = 0;
    while (frame_count !== 16'd3 && n < 200) begin
      @(negedge s_axi_aclk);
      n++;
    end
    check("frame_c_count", {16'b0, frame_count}, 32'd3);
    enable = 1'b0;
    wait_busy(1'b0, 300, "frame_d_idle");
    repeat (14) @(negedge s_axi_aclk);
    check("frame_d_count", {16'b0, frame_count}, 32'd4);
    check("frame_d_sb_empty", exp_q.size(), 32'd0);
    check("frame_d_underrun", {31'b0, underrun}, 32'd0);
    h_active = 12'd2;

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    enable = 1'b1;
    wait_busy(1'b1, 20, "frame_e_start");
    repeat (10) @(negedge s_axi_aclk);
    #1 s_axi_aresetn = 1'b0;
    #1;
    check("reset_async_outputs",
          {8'b0, pixel_tready, clink_X_clk, clink_X_data, busy, underrun, frame_count}, 32'h0);
    enable = 1'b0;
    repeat (2) @(negedge s_axi_aclk);
    #1 s_axi_aresetn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge s_axi_aclk);
      check("post_reset_clk", {31'b0, clink_X_clk}, {31'b0, pat[i]});
      check("post_reset_state", {11'b0, busy, frame_count, clink_X_data}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
